// File: rtl/eq2_run_detect.sv
// Run-length detector: compares 2-bit operand pairs, counts consecutive
// matches, and locks once RUN_LEN of them arrive in a row.
module eq2_run_detect #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eq,
  output logic [CNT_W-1:0] out_run,
  output logic             out_locked,
  output logic             out_hit,
  output logic             out_lost,
  output logic [CNT_W-1:0] match_total
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    TRACK = 2'd1,
    LOCK  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d, run_inc;
  logic [CNT_W-1:0] total_q, total_d;
  logic             valid_q, eq_q, hit_q, lost_q;
  logic             hit_d, lost_d;
  logic             eq, accept;

  assign eq       = (a[1] ~^ b[1]) & (a[0] ~^ b[0]);
  assign in_ready = reset_n && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign run_inc  = (run_q == CNT_MAX) ? run_q : run_q + CNT_W'(1);

  // State register: only accepted beats move the FSM.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      state_q <= HUNT;
    end else if (accept) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    state_d = eq ? ((RUN_LEN == 1) ? LOCK : TRACK) : HUNT;
      TRACK:   state_d = eq ? ((run_inc == RUN_LEN_C) ? LOCK : TRACK) : HUNT;
      LOCK:    state_d = eq ? LOCK : HUNT;
      default: state_d = HUNT;
    endcase
  end

  // run_q is always zero in HUNT, so the saturating increment covers every state.
  always_comb begin
    run_d   = eq ? run_inc : '0;
    hit_d   = (state_d == LOCK) && (state_q != LOCK);
    lost_d  = (state_q == LOCK) && !eq;
    total_d = (eq && (total_q != CNT_MAX)) ? total_q + CNT_W'(1) : total_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      valid_q <= 1'b0;
      eq_q    <= 1'b0;
      run_q   <= '0;
      total_q <= '0;
      hit_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      eq_q    <= eq;
      run_q   <= run_d;
      total_q <= total_d;
      hit_q   <= hit_d;
      lost_q  <= lost_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_eq      = eq_q;
  assign out_run     = run_q;
  assign out_locked  = (state_q == LOCK);
  assign out_hit     = hit_q;
  assign out_lost    = lost_q;
  assign match_total = total_q;

endmodule

// File: tb/tb_eq2_run_detect.sv
// Bench for eq2_run_detect: two instances (RUN_LEN=4/CNT_W=8 and
// RUN_LEN=2/CNT_W=3) share one stimulus stream and are scored against a run-count model.
module tb_eq2_run_detect;

  logic       clk;
  logic       reset_n, clr, in_valid, out_ready;
  logic [1:0] a, b;

  logic       in_ready0, out_valid0, out_eq0, out_locked0, out_hit0, out_lost0;
  logic [7:0] out_run0, match_total0;
  logic       in_ready1, out_valid1, out_eq1, out_locked1, out_hit1, out_lost1;
  logic [2:0] out_run1, match_total1;

  eq2_run_detect u_dut0 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready), .out_eq(out_eq0),
    .out_run(out_run0), .out_locked(out_locked0), .out_hit(out_hit0),
    .out_lost(out_lost0), .match_total(match_total0)
  );

  eq2_run_detect #(.RUN_LEN(2), .CNT_W(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready), .out_eq(out_eq1),
    .out_run(out_run1), .out_locked(out_locked1), .out_hit(out_hit1),
    .out_lost(out_lost1), .match_total(match_total1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: result register contents per instance.
  bit m_valid, m_eq;
  int m_run[2], m_total[2];
  bit m_lock[2], m_hit[2], m_lost[2];

  function automatic int run_len(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic int cnt_max(input int k);
    return (k == 0) ? 255 : 7;
  endfunction

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rn, input bit c, input bit v,
                      input logic [1:0] ia, input logic [1:0] ib, input bit ordy);
    bit exp_rdy, acc, e, old;
    reset_n = rn; clr = c; in_valid = v; a = ia; b = ib; out_ready = ordy;
    #1;
    exp_rdy = rn && (!m_valid || ordy);
    chk("in_ready0", in_ready0, exp_rdy);
    chk("in_ready1", in_ready1, exp_rdy);
    acc = v && exp_rdy;
    e   = (ia == ib);
    @(posedge clk);
    if (!rn || c) begin
      m_valid = 0; m_eq = 0;
      for (int k = 0; k < 2; k++) begin
        m_run[k] = 0; m_total[k] = 0; m_lock[k] = 0; m_hit[k] = 0; m_lost[k] = 0;
      end
    end else if (acc) begin
      m_valid = 1; m_eq = e;
      for (int k = 0; k < 2; k++) begin
        old        = m_lock[k];
        m_run[k]   = e ? ((m_run[k] + 1 > cnt_max(k)) ? cnt_max(k) : m_run[k] + 1) : 0;
        m_lock[k]  = (m_run[k] >= run_len(k));
        m_hit[k]   = m_lock[k] && !old;
        m_lost[k]  = old && !e;
        if (e && m_total[k] < cnt_max(k)) m_total[k]++;
      end
    end else if (ordy) begin
      m_valid = 0;
    end
    @(negedge clk);
    chk("out_valid0", out_valid0, m_valid);
    chk("out_eq0", out_eq0, m_eq);
    chk("out_run0", out_run0, m_run[0]);
    chk("out_locked0", out_locked0, m_lock[0]);
    chk("out_hit0", out_hit0, m_hit[0]);
    chk("out_lost0", out_lost0, m_lost[0]);
    chk("match_total0", match_total0, m_total[0]);
    chk("out_valid1", out_valid1, m_valid);
    chk("out_eq1", out_eq1, m_eq);
    chk("out_run1", out_run1, m_run[1]);
    chk("out_locked1", out_locked1, m_lock[1]);
    chk("out_hit1", out_hit1, m_hit[1]);
    chk("out_lost1", out_lost1, m_lost[1]);
    chk("match_total1", match_total1, m_total[1]);
    if (acc && rn && !c)
      $display("beat a=%0d b=%0d eq=%0d | run0=%0d lock0=%0d hit0=%0d lost0=%0d tot0=%0d | run1=%0d lock1=%0d hit1=%0d tot1=%0d",
               ia, ib, e, out_run0, out_locked0, out_hit0, out_lost0, match_total0,
               out_run1, out_locked1, out_hit1, match_total1);
  endtask

  int hits1;

  initial begin
    reset_n = 0; clr = 0; in_valid = 1; a = 2'b01; b = 2'b01; out_ready = 1;
    @(negedge clk);

    // Reset with a valid matching beat offered.
    step(0, 0, 1, 2'b01, 2'b01, 1);
    step(0, 0, 1, 2'b01, 2'b01, 1);
    step(1, 0, 1, 2'b01, 2'b01, 1);
    chk("first_run", out_run0, 1);
    chk("first_locked", out_locked0, 0);

    // Four matches lock instance 0, then a mismatch and a fresh match.
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 1, 2'd3, 2'd3, 1);
    step(1, 0, 1, 2'd0, 2'd0, 1);
    step(1, 0, 1, 2'd2, 2'd2, 1);
    step(1, 0, 1, 2'd1, 2'd1, 1);
    chk("lock_hit", out_hit0, 1);
    chk("lock_total", match_total0, 4);
    step(1, 0, 1, 2'd2, 2'd1, 1);
    chk("lost", out_lost0, 1);
    step(1, 0, 1, 2'd1, 2'd1, 1);
    chk("retrack_run", out_run0, 1);

    // Stall: drain first, then out_ready low for five cycles with data offered.
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 2'd3, 2'd3, 0);
    chk("stall_run", out_run0, 2);
    step(1, 0, 1, 2'd3, 2'd3, 1);

    // Lock, then clr alongside an accepted matching beat.
    for (int i = 0; i < 4; i++) step(1, 0, 1, 2'd0, 2'd0, 1);
    chk("pre_clr_lock", out_locked0, 1);
    step(1, 1, 1, 2'd1, 2'd1, 1);
    chk("clr_valid", out_valid0, 0);
    step(1, 0, 1, 2'd1, 2'd1, 1);
    chk("post_clr_run", out_run0, 1);

    // Saturation of the narrow instance.
    step(1, 1, 0, 0, 0, 1);
    hits1 = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, 2'd2, 2'd2, 1);
      if (out_hit1) hits1++;
    end
    chk("sat_run1", out_run1, 7);
    chk("sat_total1", match_total1, 7);
    chk("sat_hits1", hits1, 1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [1:0] ra, rb;
      ra = 2'($urandom_range(0, 3));
      rb = ($urandom_range(0, 9) < 7) ? ra : 2'($urandom_range(0, 3));
      step($urandom_range(0, 99) != 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
